// File: rtl/complex_accum.sv
// Frame accumulator for signed complex products: sums FRAME_LEN accepted samples
// with saturation, then holds the frame sum on a valid/ready port until taken.
module complex_accum #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] Re_in,
  input  logic signed [DATA_W-1:0] Im_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  Re_out,
  output logic signed [ACC_W-1:0]  Im_out,
  output logic                     overflow
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t state, state_next;

  logic signed [ACC_W-1:0] acc_re, acc_im;
  logic [CNT_W-1:0]        cnt;
  logic                    frame_ovf;

  logic                    accept, last;
  logic signed [ACC_W:0]   sum_re, sum_im;
  logic signed [ACC_W-1:0] sat_re, sat_im;
  logic                    clamp_re, clamp_im, clamp;

  assign in_ready  = (state == ACCUM) && !rst;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == LAST_CNT);

  // One extra bit of headroom; the top two bits disagree exactly when the
  // true sum falls outside the ACC_W signed range.
  assign sum_re = {acc_re[ACC_W-1], acc_re} + {{(ACC_W+1-DATA_W){Re_in[DATA_W-1]}}, Re_in};
  assign sum_im = {acc_im[ACC_W-1], acc_im} + {{(ACC_W+1-DATA_W){Im_in[DATA_W-1]}}, Im_in};

  always_comb begin
    sat_re   = sum_re[ACC_W-1:0];
    sat_im   = sum_im[ACC_W-1:0];
    clamp_re = 1'b0;
    clamp_im = 1'b0;
    if (sum_re[ACC_W:ACC_W-1] == 2'b01) begin
      sat_re   = SAT_MAX;
      clamp_re = 1'b1;
    end else if (sum_re[ACC_W:ACC_W-1] == 2'b10) begin
      sat_re   = SAT_MIN;
      clamp_re = 1'b1;
    end
    if (sum_im[ACC_W:ACC_W-1] == 2'b01) begin
      sat_im   = SAT_MAX;
      clamp_im = 1'b1;
    end else if (sum_im[ACC_W:ACC_W-1] == 2'b10) begin
      sat_im   = SAT_MIN;
      clamp_im = 1'b1;
    end
  end

  assign clamp = clamp_re || clamp_im;

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (accept && last) state_next = HOLD;
      HOLD:  if (out_ready)      state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // The last sample of a frame goes straight into the output registers so the
  // result appears one cycle after its accept, and the accumulators restart clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_re    <= '0;
      acc_im    <= '0;
      cnt       <= '0;
      frame_ovf <= 1'b0;
      Re_out    <= '0;
      Im_out    <= '0;
      overflow  <= 1'b0;
    end else if (accept) begin
      if (last) begin
        Re_out    <= sat_re;
        Im_out    <= sat_im;
        overflow  <= frame_ovf || clamp;
        acc_re    <= '0;
        acc_im    <= '0;
        cnt       <= '0;
        frame_ovf <= 1'b0;
      end else begin
        acc_re    <= sat_re;
        acc_im    <= sat_im;
        cnt       <= cnt + 1'b1;
        frame_ovf <= frame_ovf || clamp;
      end
    end
  end

endmodule
